mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 115 +++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: captures one request, waits WAIT_CYC
// cycles, accesses the internal word RAM, then pulses a one-cycle response.
module mem_responder #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              legal_c;
  logic [IDX_W-1:0]  idx_c;

  // Unsigned compare over the full address width, one extra bit so DEPTH=2**ADDR_W fits
  assign legal_c = {1'b0, addr_q} < DEPTH_L;
  assign idx_c   = addr_q[IDX_W-1:0];

  // RAM is never reset; a write lands only on the edge that leaves ACCESS
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && wr_q && legal_c) begin
      mem[idx_c] <= wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            wr_q      <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYC > 0) begin
              state <= S_WAIT;
              cnt   <= CNT_W'(WAIT_CYC - 1);
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_ACCESS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ACCESS: begin
          if (legal_c) begin
            rsp_err <= 1'b0;
            if (!wr_q) begin
              rsp_rdata <= mem[idx_c];
            end
          end else begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 has WAIT_CYC=2/DEPTH=128,
// instance 1 has WAIT_CYC=0/DEPTH=256; a monitor checks every cycle.
module tb_mem_responder;

  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid [NI];
  logic       req_write [NI];
  logic [7:0] req_addr  [NI];
  logic [7:0] req_wdata [NI];
  logic       req_ready [NI];
  logic       rsp_valid [NI];
  logic [7:0] rsp_rdata [NI];
  logic       rsp_err   [NI];
  logic       busy      [NI];

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYC(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  typedef struct {
    int         inst;
    int         cyc;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
  } ent_t;

  ent_t       sb [$];
  logic [7:0] model_mem   [NI][256];
  logic [7:0] model_rdata [NI];
  int         acc_cyc     [NI];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;

  function automatic int wait_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? 128 : 256;
  endfunction

  task automatic chk(input string name, input int i, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s inst%0d at cycle %0d: got %0h, expected %0h", name, i, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshake shape every cycle, and responses against the queue head
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        bit   in_flight;
        ent_t e;
        in_flight = (acc_cyc[i] >= 0) && (cyc >= acc_cyc[i]) &&
                    (cyc <= acc_cyc[i] + wait_of(i) + 1);
        chk("req_ready", i, int'(req_ready[i]), int'(!in_flight));
        chk("busy", i, int'(busy[i]), int'(in_flight));
        if (sb.size() > 0 && sb[0].inst == i && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          chk("rsp_valid", i, int'(rsp_valid[i]), 1);
          chk("rsp_rdata", i, int'(rsp_rdata[i]), int'(e.rdata));
          chk("rsp_err", i, int'(rsp_err[i]), int'(e.err));
          if (!e.err && e.wr) model_mem[i][e.addr] = e.wdata;
          model_rdata[i] = e.rdata;
        end else begin
          chk("no_rsp_expected", i, int'(rsp_valid[i]), 0);
        end
      end
    end
  end

  // Present a request and wait (bounded) until it is accepted; req_valid stays high
  task automatic issue(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
    int   n;
    ent_t e;
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = a;
    req_wdata[i] = d;
    n = 0;
    while (!req_ready[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      chk("accept_timeout", i, int'(req_ready[i]), 1);
      req_valid[i] = 1'b0;
      return;
    end
    acc_cyc[i] = cyc + 1;
    e.inst  = i;
    e.cyc   = cyc + 1 + wait_of(i) + 1;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = d;
    e.err   = (int'(a) >= depth_of(i));
    e.rdata = e.err ? 8'h00 : (wr ? model_rdata[i] : model_mem[i][a]);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int i, input int n);
    req_valid[i] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input int i);
    chk("rst_req_ready", i, int'(req_ready[i]), 1);
    chk("rst_rsp_valid", i, int'(rsp_valid[i]), 0);
    chk("rst_rsp_rdata", i, int'(rsp_rdata[i]), 0);
    chk("rst_rsp_err", i, int'(rsp_err[i]), 0);
    chk("rst_busy", i, int'(busy[i]), 0);
  endtask

  task automatic clear_model_on_reset();
    sb.delete();
    for (int i = 0; i < NI; i++) begin
      acc_cyc[i]     = -1000;
      model_rdata[i] = 8'h00;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 0, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    int a2;
    logic [7:0] a;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 8'h00;
      req_wdata[i] = 8'h00;
      for (int k = 0; k < 256; k++) model_mem[i][k] = 8'h00;
    end
    clear_model_on_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    #1 rst = 1'b0;
    @(negedge clk);

    // Basic write/read with two wait states
    issue(0, 1'b1, 8'h10, 8'hA5);
    issue(0, 1'b0, 8'h10, 8'h00);
    idle(0, 2);
    // Never-written location, then out-of-range read and write, then legal read
    issue(0, 1'b0, 8'h7F, 8'h00);
    idle(0, 1);
    issue(0, 1'b0, 8'h80, 8'h00);
    issue(0, 1'b1, 8'h80, 8'hFF);
    issue(0, 1'b0, 8'h00, 8'h00);
    idle(0, 1);

    // One-cycle request pulse while the responder sits in WAIT must be ignored
    issue(0, 1'b1, 8'h30, 8'h55);
    req_write[0] = 1'b1;
    req_addr[0]  = 8'h20;
    req_wdata[0] = 8'hEE;
    @(negedge clk);
    idle(0, 4);
    issue(0, 1'b0, 8'h20, 8'h00);
    issue(0, 1'b0, 8'h30, 8'h00);
    idle(0, 1);

    // Reset during WAIT discards the in-flight write
    issue(0, 1'b1, 8'h05, 8'h11);
    issue(0, 1'b0, 8'h05, 8'h00);
    issue(0, 1'b1, 8'h05, 8'h77);
    req_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset(0);
    clear_model_on_reset();
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    issue(0, 1'b0, 8'h05, 8'h00);
    idle(0, 1);

    // Randomized traffic on the wait-state, partial-depth instance
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
      issue(0, 1'($urandom_range(0, 1)), a, 8'($urandom));
      idle(0, $urandom_range(0, 3));
    end
    drain();

    // Zero wait states, req_valid held across both requests
    issue(1, 1'b1, 8'h00, 8'h3C);
    a1 = acc_cyc[1];
    issue(1, 1'b0, 8'h00, 8'h00);
    a2 = acc_cyc[1];
    chk("b2b_accept_gap", 1, a2 - a1, 3);
    idle(1, 1);

    // Randomized traffic on the zero-wait, full-depth instance
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(250, 255));
      issue(1, 1'($urandom_range(0, 1)), a, 8'($urandom));
      idle(1, $urandom_range(0, 2));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
